// File: rtl/vad_pkg.sv
// rtl/vad_pkg.sv - shared state encodings and default parameters for the VAD smoothing stage
package vad_pkg;

    // 2'd3 is never entered; the FSM steers it back to SILENCE on the next frame
    typedef enum logic [1:0] {
        SILENCE  = 2'd0,
        SPEECH   = 2'd1,
        HANGOVER = 2'd2
    } vad_state_e;

    localparam int DEF_WIN_LEN     = 8;
    localparam int DEF_ON_THRESH   = 5;
    localparam int DEF_OFF_THRESH  = 2;
    localparam int DEF_HANG_FRAMES = 3;

endpackage

// File: rtl/vad_hangover_if.sv
// rtl/vad_hangover_if.sv - classifier-decision input and smoothed VAD output bundle
interface vad_hangover_if;
    import vad_pkg::*;

    logic       tvalid_prediction;
    logic       prediction;
    logic       tvalid_vad;
    logic       vad_flag;
    logic       speech_start;
    logic       speech_end;
    vad_state_e vad_state;

    // Upstream side: drives frame decisions, observes the smoothed result
    modport master (
        output tvalid_prediction, prediction,
        input  tvalid_vad, vad_flag, speech_start, speech_end, vad_state
    );

    // Smoothing block side
    modport slave (
        input  tvalid_prediction, prediction,
        output tvalid_vad, vad_flag, speech_start, speech_end, vad_state
    );

endinterface

// File: rtl/sliding_window_count.sv
// rtl/sliding_window_count.sv - shift-register window of recent decisions with running popcount
module sliding_window_count
    import vad_pkg::*;
#(
    parameter  int WIN_LEN = DEF_WIN_LEN,
    localparam int CW      = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept_i,
    input  logic          bit_i,
    output logic [CW-1:0] cnt_next_o
);

    logic [WIN_LEN-1:0] window_q, window_d;
    logic [CW-1:0]      count_q,  count_d;

    // Count after this frame: newest bit enters, oldest leaves; the oldest
    // bit is already inside count_q so the subtraction never underflows
    always_comb begin
        cnt_next_o = count_q + CW'(bit_i) - CW'(window_q[WIN_LEN-1]);
        window_d   = window_q;
        count_d    = count_q;
        if (clear) begin
            window_d = '0;
            count_d  = '0;
        end else if (accept_i) begin
            window_d = {window_q[WIN_LEN-2:0], bit_i};
            count_d  = cnt_next_o;
        end
    end

    // Window and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_q <= '0;
            count_q  <= '0;
        end else begin
            window_q <= window_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vad_hangover.sv
// rtl/vad_hangover.sv - majority-window plus hangover smoothing of per-frame speech decisions
module vad_hangover
    import vad_pkg::*;
#(
    parameter int WIN_LEN     = DEF_WIN_LEN,
    parameter int ON_THRESH   = DEF_ON_THRESH,
    parameter int OFF_THRESH  = DEF_OFF_THRESH,
    parameter int HANG_FRAMES = DEF_HANG_FRAMES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    vad_hangover_if.slave bus
);

    localparam int CW = $clog2(WIN_LEN + 1);

    logic          accept;
    logic [CW-1:0] cnt_next;

    vad_state_e    state_q,  state_d;
    logic [7:0]    hang_q,   hang_d;
    logic          tvalid_q, tvalid_d;
    logic          flag_q,   flag_d;
    logic          start_q,  start_d;
    logic          end_q,    end_d;

    // clear wins over a coincident frame, which is then dropped
    assign accept = bus.tvalid_prediction & ~clear;

    sliding_window_count #(
        .WIN_LEN (WIN_LEN)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .accept_i   (accept),
        .bit_i      (bus.prediction),
        .cnt_next_o (cnt_next)
    );

    // Next-state and registered outputs; FSM only advances on accepted frames
    always_comb begin
        state_d  = state_q;
        hang_d   = hang_q;
        flag_d   = flag_q;
        tvalid_d = 1'b0;
        start_d  = 1'b0;
        end_d    = 1'b0;
        if (clear) begin
            state_d = SILENCE;
            hang_d  = '0;
            flag_d  = 1'b0;
        end else if (accept) begin
            tvalid_d = 1'b1;
            case (state_q)
                SILENCE: begin
                    if (cnt_next >= CW'(ON_THRESH)) begin
                        state_d = SPEECH;
                        start_d = 1'b1;
                    end
                end
                SPEECH: begin
                    if (cnt_next <= CW'(OFF_THRESH)) begin
                        state_d = HANGOVER;
                        hang_d  = 8'(HANG_FRAMES);
                    end
                end
                HANGOVER: begin
                    // Re-entering speech during hangover is a continuation, not a new onset
                    if (cnt_next >= CW'(ON_THRESH)) begin
                        state_d = SPEECH;
                    end else if (hang_q == 8'd0) begin
                        state_d = SILENCE;
                        end_d   = 1'b1;
                    end else begin
                        hang_d = hang_q - 8'd1;
                    end
                end
                default: state_d = SILENCE;
            endcase
            flag_d = (state_d != SILENCE);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SILENCE;
            hang_q   <= '0;
            tvalid_q <= 1'b0;
            flag_q   <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hang_q   <= hang_d;
            tvalid_q <= tvalid_d;
            flag_q   <= flag_d;
            start_q  <= start_d;
            end_q    <= end_d;
        end
    end

    assign bus.tvalid_vad   = tvalid_q;
    assign bus.vad_flag     = flag_q;
    assign bus.speech_start = start_q;
    assign bus.speech_end   = end_q;
    assign bus.vad_state    = state_q;

endmodule

// File: tb/tb_vad_hangover.sv
// tb/tb_vad_hangover.sv - scoreboard bench for vad_hangover with directed frame sequences
module tb_vad_hangover;
    import vad_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    vad_hangover_if vif ();

    vad_hangover #(
        .WIN_LEN     (8),
        .ON_THRESH   (5),
        .OFF_THRESH  (2),
        .HANG_FRAMES (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (vif.slave)
    );

    typedef struct packed {
        logic       flag;
        logic       start;
        logic       fin;
        logic [1:0] state;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_strobe = 1'b0;
    logic       exp_clr    = 1'b0;
    logic       last_flag  = 1'b0;
    logic [1:0] last_state = 2'd0;

    // Bench-side record of what was presented at each edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_strobe <= 1'b0;
            exp_clr    <= 1'b0;
        end else begin
            exp_strobe <= vif.tvalid_prediction & ~clear;
            exp_clr    <= clear;
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            last_flag  = 1'b0;
            last_state = 2'd0;
            n_tests++;
            if ({vif.tvalid_vad, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state} !== 6'd0) begin
                n_fail++;
                $display("FAIL in_reset: got v=%b f=%b s=%b e=%b st=%0d want all 0",
                         vif.tvalid_vad, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state);
            end
        end else begin
            if (exp_clr) begin
                last_flag  = 1'b0;
                last_state = 2'd0;
            end
            n_tests++;
            if (vif.tvalid_vad !== exp_strobe) begin
                n_fail++;
                $display("FAIL strobe_timing at %0t: got tvalid_vad=%b want %b", $time, vif.tvalid_vad, exp_strobe);
            end
            if (vif.tvalid_vad === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe at %0t: got tvalid_vad=1 want no output", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state} !== mon_e) begin
                        n_fail++;
                        $display("FAIL frame_result at %0t: got f=%b s=%b e=%b st=%0d want f=%b s=%b e=%b st=%0d",
                                 $time, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state,
                                 mon_e.flag, mon_e.start, mon_e.fin, mon_e.state);
                    end
                    last_flag  = mon_e.flag;
                    last_state = mon_e.state;
                end
            end else begin
                n_tests++;
                if ({vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state} !== {last_flag, 2'b00, last_state}) begin
                    n_fail++;
                    $display("FAIL idle_hold at %0t: got f=%b s=%b e=%b st=%0d want f=%b s=0 e=0 st=%0d",
                             $time, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state,
                             last_flag, last_state);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic p, input logic f, input logic s, input logic e,
                         input logic [1:0] st, input int gap);
        exp_t x;
        x.flag  = f;
        x.start = s;
        x.fin   = e;
        x.state = st;
        exp_q.push_back(x);
        vif.tvalid_prediction = 1'b1;
        vif.prediction        = p;
        @(posedge clk);
        #1;
        vif.tvalid_prediction = 1'b0;
        vif.prediction        = 1'b0;
        idle(gap);
    endtask

    task automatic check_all_zero(input string name);
        n_tests++;
        if ({vif.tvalid_vad, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state} !== 6'd0) begin
            n_fail++;
            $display("FAIL %s: got v=%b f=%b s=%b e=%b st=%0d want all 0", name,
                     vif.tvalid_vad, vif.vad_flag, vif.speech_start, vif.speech_end, vif.vad_state);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.tvalid_prediction = 1'b0;
        vif.prediction        = 1'b0;
        idle(3);
        check_all_zero("reset_state");
        rst = 1'b1;
        idle(1);

        // Onset after window fill, then drop and hangover; idle gaps 0..7 between frames
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 1);
        frame(1, 0, 0, 0, 2'd0, 2);
        frame(1, 0, 0, 0, 2'd0, 3);
        frame(1, 1, 1, 0, 2'd1, 4);
        frame(1, 1, 0, 0, 2'd1, 5);
        frame(1, 1, 0, 0, 2'd1, 6);
        frame(1, 1, 0, 0, 2'd1, 7);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 1);
        frame(0, 1, 0, 0, 2'd1, 2);
        frame(0, 1, 0, 0, 2'd1, 3);
        frame(0, 1, 0, 0, 2'd1, 4);
        frame(0, 1, 0, 0, 2'd2, 5);
        frame(0, 1, 0, 0, 2'd2, 6);
        frame(0, 1, 0, 0, 2'd2, 7);
        frame(0, 1, 0, 0, 2'd2, 0);
        frame(0, 0, 0, 1, 2'd0, 2);

        // Return from hangover to speech with no new onset pulse (back-to-back)
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 1, 1, 0, 2'd1, 0);
        frame(1, 1, 0, 0, 2'd1, 0);
        frame(1, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(1, 1, 0, 0, 2'd1, 0);
        frame(1, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd2, 0);
        frame(1, 1, 0, 0, 2'd2, 0);
        frame(1, 1, 0, 0, 2'd2, 0);
        frame(1, 1, 0, 0, 2'd1, 1);

        // clear coincident with a frame while in SPEECH: frame dropped, window emptied
        vif.tvalid_prediction = 1'b1;
        vif.prediction        = 1'b1;
        clear                 = 1'b1;
        @(posedge clk);
        #1;
        clear                 = 1'b0;
        vif.tvalid_prediction = 1'b0;
        vif.prediction        = 1'b0;
        idle(2);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 1, 1, 0, 2'd1, 0);

        // Into hangover, then asynchronous reset mid-cycle
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd1, 0);
        frame(0, 1, 0, 0, 2'd2, 2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        idle(2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(1);

        // Normal operation after release
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 0, 0, 0, 2'd0, 0);
        frame(1, 1, 1, 0, 2'd1, 3);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs: got %0d pending expectations want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vad_hangover.md
Name: vad_hangover

Overview:
- Decision-smoothing stage placed directly downstream of the LinearSVC classifier output (tvalid_prediction, prediction).
- Converts noisy per-frame SVM decisions into a stable voice-activity flag.
- Smoothing uses a sliding-window majority count plus a hangover state machine.
- Emits speech_start/speech_end event pulses for the system controller.

Parameters:
- WIN_LEN, 8: number of most recent frame predictions in the sliding window (2..32).
- ON_THRESH, 5: window count at or above which speech is declared.
- OFF_THRESH, 2: window count at or below which SPEECH enters HANGOVER. Legal iff 0 <= OFF_THRESH < ON_THRESH <= WIN_LEN.
- HANG_FRAMES, 3: extra frames the flag is held high after the drop frame (>=1, <=255).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset. Asserted low clears all state immediately.
- clear, input, 1: synchronous flush. Returns block to post-reset state on next edge.
- tvalid_prediction, input, 1: one-cycle strobe, one per audio frame.
- prediction, input, 1: SVM decision for the frame (1 = speech); sampled only when tvalid_prediction=1.
- tvalid_vad, output, 1: one-cycle strobe, one per accepted input frame.
- vad_flag, output, 1: smoothed voice-activity decision; valid with tvalid_vad, held between strobes.
- speech_start, output, 1: one-cycle pulse coincident with tvalid_vad on a SILENCE->SPEECH transition.
- speech_end, output, 1: one-cycle pulse coincident with tvalid_vad on a HANGOVER->SILENCE transition.
- vad_state, output, 2: current FSM state, for debug and ILA.

Behaviour:
- Reset, rst=0 or clear=1: window shift register all 0, count=0, state=SILENCE, hang_cnt=0, all outputs 0.
- Priority: rst > clear > tvalid_prediction. If clear=1 and tvalid_prediction=1 in the same cycle, the frame is dropped and no tvalid_vad is produced.
- Accepted frame (tvalid_prediction=1, clear=0):
  - Shift prediction into the window; the oldest bit falls out.
  - cnt_next = count + prediction - oldest, width $clog2(WIN_LEN+1), never wraps.
  - Evaluate the FSM using cnt_next.
- Latency: exactly 1 cycle. On the edge after acceptance, tvalid_vad=1 together with updated vad_flag, vad_state and any event pulse.
- Back-to-back valids are supported at full rate. Cycles without tvalid_prediction change nothing except dropping the strobes/pulses to 0.
- Window start-up: the window fills from zeros after reset or clear. With default parameters, the first possible speech decision is on the 5th frame.
- FSM, evaluated only on accepted frames:
  - SILENCE: if cnt_next >= ON_THRESH -> SPEECH, speech_start=1. Otherwise stay. vad_flag follows next state.
  - SPEECH: if cnt_next <= OFF_THRESH -> HANGOVER, load hang_cnt=HANG_FRAMES, vad_flag stays 1. Otherwise stay.
  - HANGOVER:
    - If cnt_next >= ON_THRESH -> SPEECH, no speech_start pulse.
    - Else if hang_cnt==0 -> SILENCE, vad_flag=0, speech_end=1.
    - Else hang_cnt-=1 and stay, vad_flag=1.
  - Effect: after the drop frame, vad_flag stays high for exactly HANG_FRAMES more frames and falls on the next one.
- vad_flag = 1 iff next state is SPEECH or HANGOVER.
- speech_start and speech_end are never both 1.
- Async reset mid-hangover: flag drops immediately, with no speech_end pulse.

Decomposition:
- Shared package vad_pkg holds:
  - state encodings: SILENCE=2'd0, SPEECH=2'd1, HANGOVER=2'd2 (2'd3 illegal, recovers to SILENCE);
  - default WIN_LEN, ON_THRESH, OFF_THRESH, HANG_FRAMES values, reused by the pipeline top.
- One sub-module, sliding_window_count: parameterised shift register plus running popcount. Produces cnt_next combinationally and registers count on accept/clear.

Test Plan (WIN_LEN=8, ON=5, OFF=2, HANG=3):
- Reset, then 5 frames of 1 -> frames 1-4: tvalid_vad=1, vad_flag=0. Frame 5: vad_flag=1, speech_start=1, vad_state=1.
- 8 frames of 1, then 0s:
  - zero #6 (count=2) -> vad_state=2, vad_flag=1;
  - zeros #7-#9 -> vad_flag=1;
  - zero #10 -> vad_flag=0, speech_end=1, vad_state=0.
- In HANGOVER after zero #6, feed 1s until count>=5 -> state returns to SPEECH, vad_flag stays 1 throughout, no speech_start.
- Frames spaced with 0-7 idle cycles -> each tvalid_vad occurs exactly 1 cycle after its tvalid_prediction. No extra strobes; outputs unchanged in idle cycles.
- clear=1 coincident with tvalid_prediction=1 while in SPEECH -> no tvalid_vad, state=SILENCE, count=0. The next 4 frames of 1 give vad_flag=0.
- rst pulled low asynchronously, mid-cycle, during HANGOVER -> all outputs 0 before the next clk edge, no speech_end. Operation resumes normally after release.
